// File: rtl/ifetch_pq.sv
// Instruction-fetch stage: a fetch PC prefetches sequential words into a circular
// queue and delivers (pc, inst) pairs to decode; a redirect flushes and restarts.
module ifetch_pq #(
  parameter int              XLEN           = 32,
  parameter int              PQ_DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC       = {XLEN{1'b0}},
  parameter int              BYTES_PER_WORD = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            fd_valid,
  input  logic            fd_ready,
  output logic [XLEN-1:0] fd_pc,
  output logic [XLEN-1:0] fd_inst
);

  localparam int              PW         = $clog2(PQ_DEPTH);
  localparam int              CW         = PW + 1;
  localparam int              DW         = $clog2(2 * PQ_DEPTH) + 1;
  localparam logic [DW:0]     DEPTH_W    = (DW + 1)'(PQ_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(BYTES_PER_WORD);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN - 2){1'b1}}, 2'b00};

  logic [XLEN-1:0]     pc_q   [PQ_DEPTH];
  logic [XLEN-1:0]     inst_q [PQ_DEPTH];
  logic [PQ_DEPTH-1:0] filled;
  logic [PW-1:0]       alloc_ptr, fill_ptr, head_ptr;
  logic [CW-1:0]       count;
  logic [DW-1:0]       drop_cnt;
  logic [XLEN-1:0]     fetch_pc;

  logic [DW:0]   occupancy;
  logic          issue, pop, rsp_drop, rsp_fill;
  logic [CW-1:0] filled_cnt, pending;
  logic [DW-1:0] drop_flush;

  // Issue is throttled by queued entries plus responses still owed to a flushed stream.
  always_comb begin
    occupancy      = (DW + 1)'(count) + (DW + 1)'(drop_cnt);
    imem_req_valid = rst_n && !redir_valid && (occupancy < DEPTH_W);
    imem_req_addr  = fetch_pc & ALIGN_MASK;
    fd_valid       = !redir_valid && (count != {CW{1'b0}}) && filled[head_ptr];
    fd_pc          = pc_q[head_ptr];
    fd_inst        = inst_q[head_ptr];
    issue          = imem_req_valid && imem_req_ready;
    pop            = fd_valid && fd_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != {DW{1'b0}});
    rsp_fill       = imem_rsp_valid && (drop_cnt == {DW{1'b0}});
  end

  // Responses still in flight at a redirect become stale and must be swallowed later.
  always_comb begin
    filled_cnt = {CW{1'b0}};
    for (int i = 0; i < PQ_DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(filled[i]);
    end
    pending    = count - filled_cnt;
    drop_flush = drop_cnt + DW'(pending) - DW'(imem_rsp_valid);
  end

  // Queue, pointer, fetch-PC and drop-counter state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      alloc_ptr <= {PW{1'b0}};
      fill_ptr  <= {PW{1'b0}};
      head_ptr  <= {PW{1'b0}};
      count     <= {CW{1'b0}};
      drop_cnt  <= {DW{1'b0}};
      filled    <= {PQ_DEPTH{1'b0}};
      for (int i = 0; i < PQ_DEPTH; i++) begin
        pc_q[i]   <= {XLEN{1'b0}};
        inst_q[i] <= {XLEN{1'b0}};
      end
    end else if (redir_valid) begin
      fetch_pc  <= redir_pc & ALIGN_MASK;
      alloc_ptr <= {PW{1'b0}};
      fill_ptr  <= {PW{1'b0}};
      head_ptr  <= {PW{1'b0}};
      count     <= {CW{1'b0}};
      drop_cnt  <= drop_flush;
      filled    <= {PQ_DEPTH{1'b0}};
    end else begin
      if (pop) begin
        filled[head_ptr] <= 1'b0;
        head_ptr         <= head_ptr + PW'(1);
      end
      if (issue) begin
        pc_q[alloc_ptr]   <= fetch_pc;
        filled[alloc_ptr] <= 1'b0;
        alloc_ptr         <= alloc_ptr + PW'(1);
        fetch_pc          <= fetch_pc + PC_STEP;
      end
      if (rsp_fill) begin
        inst_q[fill_ptr] <= imem_rsp_data;
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + PW'(1);
      end
      if (rsp_drop) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
      case ({issue, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_pq.sv
// Directed bench for ifetch_pq with a fixed-latency in-order memory model whose
// instruction word is the bitwise inverse of its address.
module tb_ifetch_pq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_pc;
  logic [31:0] fd_inst;

  int          errors = 0;
  int          checks = 0;
  int          req_cnt = 0;
  int          base;
  logic [1:0]  lat_m1;
  logic [3:0]  pv;
  logic [31:0] pa [4];

  ifetch_pq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .fd_valid       (fd_valid),
    .fd_ready       (fd_ready),
    .fd_pc          (fd_pc),
    .fd_inst        (fd_inst)
  );

  always #5 clk = ~clk;

  // Memory: response appears lat_m1+1 cycles after the accepting edge; cleared by reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= 4'b0000;
    end else begin
      pv    <= {pv[2:0], imem_req_valid && imem_req_ready};
      pa[0] <= imem_req_addr;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
      if (imem_req_valid && imem_req_ready) req_cnt <= req_cnt + 1;
    end
  end

  assign imem_rsp_valid = pv[lat_m1];
  assign imem_rsp_data  = ~pa[lat_m1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    fd_ready    = 1'b1;
    lat_m1      = 2'd0;

    // Reset state
    @(negedge clk); #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_fd_valid",  32'(fd_valid), 32'd0);
    check("rst_fd_pc",     fd_pc, 32'h0);
    check("rst_fd_inst",   fd_inst, 32'h0);

    // Streaming with 1-cycle memory
    @(negedge clk); rst_n = 1'b1; #1;
    check("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("c0_req_addr",  imem_req_addr, 32'h0);
    check("c0_fd_valid",  32'(fd_valid), 32'd0);
    @(negedge clk); #1;
    check("c1_fd_valid",  32'(fd_valid), 32'd0);
    check("c1_req_addr",  imem_req_addr, 32'h4);
    for (int t = 2; t < 8; t++) begin
      @(negedge clk); #1;
      check("stream_fd_valid", 32'(fd_valid), 32'd1);
      check("stream_fd_pc",    fd_pc, 32'(4 * (t - 2)));
      check("stream_fd_inst",  fd_inst, ~32'(4 * (t - 2)));
    end

    // Mid-stream reset, then decode stall
    @(negedge clk); rst_n = 1'b0; fd_ready = 1'b0; #1;
    check("rst_gates_req", 32'(imem_req_valid), 32'd0);
    @(negedge clk); #1;
    check("midrst_fd_valid", 32'(fd_valid), 32'd0);
    check("midrst_fd_pc",    fd_pc, 32'h0);
    @(negedge clk); rst_n = 1'b1; base = req_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("stall_issue_count", 32'(req_cnt - base), 32'd4);
    check("stall_req_valid",   32'(imem_req_valid), 32'd0);
    check("stall_fd_valid",    32'(fd_valid), 32'd1);
    check("stall_fd_pc",       fd_pc, 32'h0);
    check("stall_fd_inst",     fd_inst, ~32'h0);
    fd_ready = 1'b1; #1;
    check("full_no_bypass", 32'(imem_req_valid), 32'd0);
    @(negedge clk); #1;
    check("resume_req_valid", 32'(imem_req_valid), 32'd1);
    check("resume_req_addr",  imem_req_addr, 32'h10);
    check("drain_fd_pc_4",    fd_pc, 32'h4);
    for (int t = 2; t < 5; t++) begin
      @(negedge clk); #1;
      check("drain_fd_valid", 32'(fd_valid), 32'd1);
      check("drain_fd_pc",    fd_pc, 32'(4 * t));
    end

    // 3-cycle memory: redirect with three requests in flight
    @(negedge clk); rst_n = 1'b0; lat_m1 = 2'd2;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); redir_valid = 1'b1; redir_pc = 32'h100; #1;
    check("redir_req_blocked", 32'(imem_req_valid), 32'd0);
    check("redir_fd_blocked",  32'(fd_valid), 32'd0);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("redir_req_addr", imem_req_addr, 32'h100);
    check("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check("stale_drop_fd_valid", 32'(fd_valid), 32'd0);
    for (int t = 5; t < 8; t++) begin
      @(negedge clk); #1;
      check("stale_drop_fd_valid", 32'(fd_valid), 32'd0);
    end
    @(negedge clk); #1;
    check("redir_fd_pc",   fd_pc, 32'h100);
    check("redir_fd_inst", fd_inst, ~32'h100);

    // Redirect colliding with a response and a decode handshake
    @(negedge clk); #1;
    check("pre_collide_fd_valid", 32'(fd_valid), 32'd1);
    check("pre_collide_fd_pc",    fd_pc, 32'h104);
    check("pre_collide_rsp",      32'(imem_rsp_valid), 32'd1);
    redir_valid = 1'b1; redir_pc = 32'h203; #1;
    check("collide_fd_valid",  32'(fd_valid), 32'd0);
    check("collide_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("unaligned_req_addr", imem_req_addr, 32'h200);
    check("collide_drop_fd_valid", 32'(fd_valid), 32'd0);
    for (int t = 11; t < 14; t++) begin
      @(negedge clk); #1;
      check("collide_drop_fd_valid", 32'(fd_valid), 32'd0);
    end
    @(negedge clk); #1;
    check("collide_fd_pc",   fd_pc, 32'h200);
    check("collide_fd_inst", fd_inst, ~32'h200);

    // Address wrap at the top of the space, then reset mid-stream
    @(negedge clk); rst_n = 1'b0; lat_m1 = 2'd0;
    @(negedge clk); rst_n = 1'b1; redir_valid = 1'b1; redir_pc = 32'hFFFF_FFF8; #1;
    check("wrap_redir_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk); redir_valid = 1'b0; #1;
    check("wrap_addr_fff8", imem_req_addr, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    check("wrap_addr_fffc", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap_addr_0",  imem_req_addr, 32'h0);
    check("wrap_fd_pc_0", fd_pc, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    check("wrap_fd_pc_1", fd_pc, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap_fd_pc_2",   fd_pc, 32'h0);
    check("wrap_fd_inst_2", fd_inst, ~32'h0);
    @(negedge clk); #1;
    check("wrap_fd_pc_3", fd_pc, 32'h4);
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst2_req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk); #1;
    check("rst2_fd_valid", 32'(fd_valid), 32'd0);
    check("rst2_fd_pc",    fd_pc, 32'h0);
    check("rst2_fd_inst",  fd_inst, 32'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst2_req_addr", imem_req_addr, 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    check("rst2_fd_pc_after",   fd_pc, 32'h0);
    check("rst2_fd_inst_after", fd_inst, ~32'h0);
    check("rst2_fd_valid_after", 32'(fd_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
